// File: rtl/posit_normaliser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | posit_normaliser : two-stage renormaliser between mantissa adder and     |
// |                    posit encoder (LZC, hidden-one drop, regime/exp split)|
// | Optional: POSIT_NORM_SAT_EN clamps the regime and adds out_sat.          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module posit_normaliser #(
  parameter int WIDTH = 7,
  parameter int EN    = 1,
  parameter int NBITS = 8,
  parameter int W_REG = $clog2(WIDTH) + 1,
  parameter int W_EXP = $clog2(WIDTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        mantissa_sum,
  input  logic signed [W_REG-1:0] interim_reg,
  input  logic signed [W_EXP-1:0] interim_exp,
  input  logic                    negate_result,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_sign,
  output logic signed [W_REG-1:0] out_regime,
  output logic [W_EXP-1:0]        out_exponent,
  output logic [WIDTH-1:0]        out_fraction,
  output logic                    out_zero
`ifdef POSIT_NORM_SAT_EN
  ,
  output logic                    out_sat
`endif
);

  localparam int LZW = $clog2(WIDTH + 1);
  localparam int SW  = W_REG + EN + 2;
  localparam logic [LZW:0] SH_ONE = 1;

  logic                    s1_valid_q, s2_valid_q, s1_adv;
  logic [WIDTH-1:0]        s1_man_q;
  logic signed [W_REG-1:0] s1_reg_q;
  logic signed [W_EXP-1:0] s1_exp_q;
  logic                    s1_neg_q;
  logic [LZW-1:0]          s1_lzc_q, lzc_d;

  logic signed [SW-1:0]    scale;
  logic [LZW:0]            shamt;
  logic [WIDTH-1:0]        frac_full;

  logic                    sign_d, sign_q, zero_d, zero_q;
  logic signed [W_REG-1:0] regime_d, regime_q;
  logic [W_EXP-1:0]        exponent_d, exponent_q;
  logic [WIDTH-1:0]        fraction_d, fraction_q;
`ifdef POSIT_NORM_SAT_EN
  localparam logic signed [SW-1:0] RMIN = SW'(-(NBITS - 1));
  localparam logic signed [SW-1:0] RMAX = SW'(NBITS - 2);
  logic signed [SW-1:0]    regime_full;
  logic                    sat_d, sat_q;
`endif

  // Stage 1 may move whenever stage 2 is empty or draining this cycle.
  assign s1_adv    = ~s2_valid_q | out_ready;
  assign in_ready  = ~s1_valid_q | s1_adv;
  assign out_valid = s2_valid_q;

  always_comb begin
    lzc_d = LZW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (mantissa_sum[i]) lzc_d = LZW'(WIDTH - 1 - i);
    end
  end

  assign scale     = (SW'(s1_reg_q) <<< EN) + SW'(s1_exp_q) + SW'(1) - SW'(s1_lzc_q);
  assign shamt     = {1'b0, s1_lzc_q} + SH_ONE;
  assign frac_full = s1_man_q << shamt;

  always_comb begin
    sign_d     = s1_neg_q;
    regime_d   = scale[W_REG+EN-1:EN];
    exponent_d = W_EXP'(scale[EN-1:0]);
    fraction_d = frac_full;
    zero_d     = 1'b0;
`ifdef POSIT_NORM_SAT_EN
    regime_full = scale >>> EN;
    sat_d       = 1'b0;
    if (regime_full < RMIN) begin
      regime_d   = RMIN[W_REG-1:0];
      exponent_d = '0;
      fraction_d = '0;
      sat_d      = 1'b1;
    end else if (regime_full > RMAX) begin
      regime_d   = RMAX[W_REG-1:0];
      exponent_d = '0;
      fraction_d = '0;
      sat_d      = 1'b1;
    end
`endif
    // An all-zero sum is exact zero whatever the interim fields say.
    if (s1_lzc_q == LZW'(WIDTH)) begin
      sign_d     = 1'b0;
      regime_d   = '0;
      exponent_d = '0;
      fraction_d = '0;
      zero_d     = 1'b1;
`ifdef POSIT_NORM_SAT_EN
      sat_d      = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_man_q   <= '0;
      s1_reg_q   <= '0;
      s1_exp_q   <= '0;
      s1_neg_q   <= 1'b0;
      s1_lzc_q   <= '0;
      sign_q     <= 1'b0;
      regime_q   <= '0;
      exponent_q <= '0;
      fraction_q <= '0;
      zero_q     <= 1'b0;
`ifdef POSIT_NORM_SAT_EN
      sat_q      <= 1'b0;
`endif
    end else begin
      if (in_valid && in_ready) begin
        s1_valid_q <= 1'b1;
        s1_man_q   <= mantissa_sum;
        s1_reg_q   <= interim_reg;
        s1_exp_q   <= interim_exp;
        s1_neg_q   <= negate_result;
        s1_lzc_q   <= lzc_d;
      end else if (s1_adv) begin
        s1_valid_q <= 1'b0;
      end
      if (s1_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          sign_q     <= sign_d;
          regime_q   <= regime_d;
          exponent_q <= exponent_d;
          fraction_q <= fraction_d;
          zero_q     <= zero_d;
`ifdef POSIT_NORM_SAT_EN
          sat_q      <= sat_d;
`endif
        end
      end
    end
  end

  assign out_sign     = sign_q;
  assign out_regime   = regime_q;
  assign out_exponent = exponent_q;
  assign out_fraction = fraction_q;
  assign out_zero     = zero_q;
`ifdef POSIT_NORM_SAT_EN
  assign out_sat      = sat_q;
`endif

endmodule
`default_nettype wire
